// File: rtl/adder_ring_meter.sv
// Measurement sequencer for the instrumented adder: latches operands, enables the ring
// oscillator, lets it settle, then counts synchronized ring edges over a programmable window.
module adder_ring_meter #(
    parameter int OPERAND_W     = 8,
    parameter int WINDOW_W      = 16,
    parameter int COUNT_W       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 start_i,
    input  logic [WINDOW_W-1:0]  window_i,
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    input  logic                 ring_i,
    output logic                 ring_en_o,
    output logic [OPERAND_W-1:0] adder_a_o,
    output logic [OPERAND_W-1:0] adder_b_o,
    output logic [COUNT_W-1:0]   count_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]  COUNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    state_t               state_q,    state_d;
    logic [SETTLE_W-1:0]  settle_q,   settle_d;
    logic [WINDOW_W-1:0]  window_q,   window_d;
    logic [WINDOW_W-1:0]  win_cnt_q,  win_cnt_d;
    logic [COUNT_W-1:0]   count_q,    count_d;
    logic                 overflow_q, overflow_d;
    logic [OPERAND_W-1:0] a_q,        a_d;
    logic [OPERAND_W-1:0] b_q,        b_d;
    logic                 start_q,    start_d;
    logic [2:0]           ring_sync_q, ring_sync_d;
    logic                 ring_en_q,  ring_en_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic start_pulse;
    logic ring_rise;

    assign start_pulse = start_i & ~start_q;
    // Bits [1] and [2] are the second and third synchronizer stages.
    assign ring_rise   = ring_sync_q[1] & ~ring_sync_q[2];

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        window_d    = window_q;
        win_cnt_d   = win_cnt_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        a_d         = a_q;
        b_d         = b_q;
        start_d     = start_i;
        ring_sync_d = {ring_sync_q[1:0], ring_i};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_pulse) begin
                    a_d        = a_i;
                    b_d        = b_i;
                    window_d   = window_i;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    if (window_i != '0) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d   = ST_MEASURE;
                    win_cnt_d = window_q - WINDOW_W'(1);
                end else begin
                    settle_d  = settle_q - SETTLE_W'(1);
                end
            end
            ST_MEASURE: begin
                // Saturate rather than wrap so a too-fast ring is visible as overflow.
                if (ring_rise) begin
                    if (count_q == COUNT_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end
                if (win_cnt_q == '0) begin
                    state_d   = ST_DONE;
                end else begin
                    win_cnt_d = win_cnt_q - WINDOW_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Until the reset synchronizer has filled, everything is held cleared.
        if (!run) begin
            state_d     = ST_IDLE;
            settle_d    = '0;
            window_d    = '0;
            win_cnt_d   = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            a_d         = '0;
            b_d         = '0;
            start_d     = 1'b0;
            ring_sync_d = '0;
        end

        ring_en_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
        busy_d    = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            window_q    <= '0;
            win_cnt_q   <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            ring_sync_q <= '0;
            ring_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            window_q    <= window_d;
            win_cnt_q   <= win_cnt_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            start_q     <= start_d;
            ring_sync_q <= ring_sync_d;
            ring_en_q   <= ring_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ring_en_o  = ring_en_q;
    assign adder_a_o  = a_q;
    assign adder_b_o  = b_q;
    assign count_o    = count_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_adder_ring_meter.sv
// Bench for adder_ring_meter: directed and randomized measurements checked against an
// ideal edges-per-window model with +/-1 tolerance and saturation at the counter limit.
module tb_adder_ring_meter;

    localparam int SETTLE = 4;

    logic        clk;
    logic        wb_rst_n;
    logic        start_i;
    logic [15:0] window_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        ring_i;

    logic        ring_en_o, busy_o, done_o, overflow_o;
    logic [7:0]  adder_a_o, adder_b_o;
    logic [15:0] count_o;

    logic        ring_en4, busy4, done4, overflow4;
    logic [7:0]  adder_a4, adder_b4;
    logic [3:0]  count4;

    int n_assert = 0;
    int n_fail   = 0;
    int half_clk = 2;

    adder_ring_meter #(.COUNT_W(16), .SETTLE_CYCLES(SETTLE)) dut (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .start_i(start_i), .window_i(window_i),
        .a_i(a_i), .b_i(b_i), .ring_i(ring_i), .ring_en_o(ring_en_o),
        .adder_a_o(adder_a_o), .adder_b_o(adder_b_o), .count_o(count_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    adder_ring_meter #(.COUNT_W(4), .SETTLE_CYCLES(SETTLE)) dut4 (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .start_i(start_i), .window_i(window_i),
        .a_i(a_i), .b_i(b_i), .ring_i(ring_i), .ring_en_o(ring_en4),
        .adder_a_o(adder_a4), .adder_b_o(adder_b4), .count_o(count4),
        .busy_o(busy4), .done_o(done4), .overflow_o(overflow4)
    );

    // clock / ring / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ring toggles 3 ns off the clock grid; its period is 2*half_clk clock cycles.
    initial begin
        ring_i = 1'b0;
        #3;
        forever begin
            #(half_clk * 10);
            ring_i = ~ring_i;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver / checker tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [15:0] w);
        a_i      = a;
        b_i      = b;
        window_i = w;
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
    endtask

    // Called just after the accepting edge; returns edges until done and ring_en high cycles.
    task automatic run_wait(output int steps, output int en_cycles);
        steps     = 0;
        en_cycles = 0;
        while (!done_o && steps < 5000) begin
            if (ring_en_o) en_cycles++;
            step();
            steps++;
        end
        check("done_reached", done_o, 1'b1);
    endtask

    // Ideal count is w/p edges; the synchronizer phase allows +/-1, then the counter saturates.
    task automatic check_count(input string tag, input int cnt, input logic ovf,
                               input int w, input int p, input int maxv);
        if (w / p - 1 >= maxv) begin
            check({tag, "_sat"}, cnt, maxv);
            check({tag, "_ovf"}, ovf, 1'b1);
        end else begin
            check({tag, "_cnt_tol"}, (cnt * p + p >= w) && (cnt * p <= w + p), 1'b1);
            check({tag, "_ovf"}, ovf, 1'b0);
        end
    endtask

    // stimulus
    initial begin
        int steps, en_cycles, runs, w, p;
        logic prev_busy;
        logic [7:0] ra, rb;

        // Reset with random inputs and a toggling ring
        wb_rst_n = 1'b0;
        start_i  = 1'($urandom_range(0, 1));
        window_i = 16'($urandom);
        a_i      = 8'($urandom);
        b_i      = 8'($urandom);
        repeat (4) step();
        check("rst_outputs", {ring_en_o, busy_o, done_o, overflow_o, adder_a_o, adder_b_o, count_o}, '0);
        check("rst_outputs4", {ring_en4, busy4, done4, overflow4, count4}, '0);
        start_i  = 1'b0;
        wb_rst_n = 1'b1;
        step();
        step();
        check("post_release", {ring_en_o, busy_o, done_o, overflow_o, adder_a_o, adder_b_o, count_o}, '0);
        step();

        // Nominal: period 4, window 100
        half_clk = 2;
        do_start(8'h5A, 8'h3C, 16'd100);
        check("nom_a", adder_a_o, 8'h5A);
        check("nom_b", adder_b_o, 8'h3C);
        check("nom_busy", busy_o, 1'b1);
        a_i = 8'hFF;
        b_i = 8'h00;
        run_wait(steps, en_cycles);
        check("nom_latency", steps, SETTLE + 100);
        check("nom_ring_en_cycles", en_cycles, SETTLE + 100);
        check("nom_busy_done", busy_o, 1'b0);
        check_count("nom", count_o, overflow_o, 100, 4, 65535);
        check("nom_a_hold", adder_a_o, 8'h5A);

        // Zero window
        ra = 8'($urandom);
        rb = 8'($urandom);
        do_start(ra, rb, 16'd0);
        check("zero_done", done_o, 1'b1);
        check("zero_busy", busy_o, 1'b0);
        check("zero_count", count_o, 16'd0);
        check("zero_ovf", overflow_o, 1'b0);
        check("zero_a", adder_a_o, ra);
        runs = 0;
        for (int i = 0; i < 8; i++) begin
            if (ring_en_o) runs++;
            step();
        end
        check("zero_ring_en", runs, 0);

        // Saturation on the 4-bit counter
        half_clk = 1;
        do_start(8'h01, 8'h02, 16'd40);
        run_wait(steps, en_cycles);
        check("sat_latency", steps, SETTLE + 40);
        check_count("sat16", count_o, overflow_o, 40, 2, 65535);
        check_count("sat4", count4, overflow4, 40, 2, 15);
        do_start(8'h03, 8'h04, 16'd10);
        run_wait(steps, en_cycles);
        check_count("post_sat4", count4, overflow4, 10, 2, 15);

        // start held high for 300 cycles -> one run
        half_clk = 2;
        window_i = 16'd100;
        start_i  = 1'b1;
        runs      = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy_o && !prev_busy) runs++;
            prev_busy = busy_o;
        end
        check("held_runs", runs, 1);
        check("held_done", done_o, 1'b1);
        start_i = 1'b0;
        step();

        // Re-pulse during MEASURE is ignored
        do_start(8'h11, 8'h22, 16'd100);
        repeat (20) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        run_wait(steps, en_cycles);
        check("repulse_latency", steps + 23, SETTLE + 100);
        check("repulse_a", adder_a_o, 8'h11);

        // Pulse in DONE starts a new run
        do_start(8'h33, 8'h44, 16'd30);
        check("redone_done_drop", done_o, 1'b0);
        check("redone_busy", busy_o, 1'b1);
        run_wait(steps, en_cycles);
        check("redone_latency", steps, SETTLE + 30);

        // Randomized measurements
        for (int t = 0; t < 6; t++) begin
            half_clk = $urandom_range(1, 4);
            p  = 2 * half_clk;
            w  = $urandom_range(1, 150);
            ra = 8'($urandom);
            rb = 8'($urandom);
            step();
            do_start(ra, rb, 16'(w));
            a_i = 8'($urandom);
            b_i = 8'($urandom);
            run_wait(steps, en_cycles);
            check($sformatf("rnd%0d_latency", t), steps, SETTLE + w);
            check($sformatf("rnd%0d_ring_en", t), en_cycles, SETTLE + w);
            check($sformatf("rnd%0d_ops", t), {adder_a_o, adder_b_o}, {ra, rb});
            check_count($sformatf("rnd%0d", t), count_o, overflow_o, w, p, 65535);
        end

        // Reset mid-MEASURE
        half_clk = 2;
        do_start(8'h77, 8'h88, 16'd100);
        repeat (SETTLE + 50) step();
        check("mid_busy_before", busy_o, 1'b1);
        wb_rst_n = 1'b0;
        #1;
        check("mid_rst_now", {ring_en_o, busy_o, done_o, count_o, adder_a_o}, '0);
        step();
        step();
        wb_rst_n = 1'b1;
        runs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if ({ring_en_o, busy_o, done_o, overflow_o, adder_a_o, adder_b_o, count_o} != '0) runs++;
        end
        check("mid_after_release_zero", runs, 0);

        // start already high across reset release yields a fresh pulse
        wb_rst_n = 1'b0;
        window_i = 16'd5;
        start_i  = 1'b1;
        step();
        wb_rst_n = 1'b1;
        steps = 0;
        while (!busy_o && steps < 20) begin
            step();
            steps++;
        end
        check("rel_start_edges", steps, 3);
        start_i = 1'b0;
        run_wait(steps, en_cycles);
        check("rel_start_latency", steps, SETTLE + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
